serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Purpose  : Digit-serial adder; adds DIGIT bits per cycle, LSB digit first.
//            Optional subtract/overflow support under SERIAL_ADDER_SUB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
    output logic             ovf_o,
`endif
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic [DIGIT-1:0] w_da;
    logic [DIGIT-1:0] w_db;
    logic [DIGIT-1:0] w_dsum;
    logic             w_dcarry;
    logic             w_last;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;

`ifdef SERIAL_ADDER_SUB_EN
    logic r_ovf;

    // Subtraction is a + ~b + 1; the incoming carry is replaced by the +1.
    assign w_b_eff = sub_i ? ~b_i : b_i;
    assign w_cin   = sub_i ? 1'b1 : c_i;
    assign ovf_o   = r_ovf;
`else
    assign w_b_eff = b_i;
    assign w_cin   = c_i;
`endif

    // Operands shift right each cycle so the active digit is always at bit 0.
    assign w_da   = r_a[DIGIT-1:0];
    assign w_db   = r_b[DIGIT-1:0];
    assign {w_dcarry, w_dsum} = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_carry};
    assign w_last = (r_cnt == CW'(N - 1));

    assign in_ready_o  = (r_state == c_IDLE);
    assign out_valid_o = (r_state == c_DONE);
    assign sum_o       = r_sum;
    assign carry_o     = r_cout;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid_i) begin
                        r_a     <= a_i;
                        r_b     <= w_b_eff;
                        r_carry <= w_cin;
                        r_cnt   <= '0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_sum[r_cnt*DIGIT +: DIGIT] <= w_dsum;
                    r_carry <= w_dcarry;
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    if (w_last) begin
                        r_cout  <= w_dcarry;
`ifdef SERIAL_ADDER_SUB_EN
                        // Signed overflow: like-signed operands, differently signed result.
                        r_ovf   <= (w_da[DIGIT-1] == w_db[DIGIT-1]) &&
                                   (w_dsum[DIGIT-1] != w_da[DIGIT-1]);
`endif
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DONE: begin
                    if (out_ready_i) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
